// File: rtl/argo_chan_pkg.sv
// Shared constants for the argo channel reader: default word width, buffer occupancy codes, counter width.
package argo_chan_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned CNT_WIDTH      = 32;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage

// File: rtl/argo_chan_reader_if.sv
// Channel bundle: argo_fifo read port plus the outgoing valid/ready stream.
// master = reader side (pops the FIFO, sources the stream), slave = environment side.
interface argo_chan_reader_if import argo_chan_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_en;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport master (
        input  fifo_empty, fifo_rd_data, out_ready,
        output fifo_rd_en, out_valid, out_data
    );

    modport slave (
        output fifo_empty, fifo_rd_data, out_ready,
        input  fifo_rd_en, out_valid, out_data
    );
endinterface

// File: rtl/argo_skid_buf.sv
// Two-entry in-order buffer holding words captured from argo_fifo until the consumer takes them.
// state     | meaning
// OCC_EMPTY | no word held
// OCC_ONE   | one word held, head valid
// OCC_TWO   | full; the reader must not have a pop in flight
module argo_skid_buf import argo_chan_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic [1:0]            count_d;

    always_comb begin
        count_d = count_q;
        case (count_q)
            OCC_EMPTY: if (push_i) count_d = OCC_ONE;
            OCC_ONE: begin
                if (push_i && !pop_i)      count_d = OCC_TWO;
                else if (!push_i && pop_i) count_d = OCC_EMPTY;
            end
            OCC_TWO: if (pop_i && !push_i) count_d = OCC_ONE;
            default: count_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= OCC_EMPTY;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/argo_chan_reader.sv
// Turns the 1-cycle-latency argo_fifo read port into a valid/ready stream at up to 1 word/cycle.
// Optional statistics counters are built only when ARGO_CHAN_STATS_EN is defined.
module argo_chan_reader import argo_chan_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int          CHAN_ID    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    argo_chan_reader_if.master   bus
`ifdef ARGO_CHAN_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] pop_count,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] starve_count
`endif
);

    if (DATA_WIDTH < 1 || CHAN_ID < 0) begin : g_param_check
        $error("argo_chan_reader: DATA_WIDTH must be >= 1 and CHAN_ID >= 0");
    end

    logic                  inflight_q;
    logic                  inflight_d;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  out_valid_w;
    logic                  xfer;
    logic                  rd_en;
    logic [2:0]            demand;

    assign out_valid_w = !rst && (occ != OCC_EMPTY);
    assign xfer        = out_valid_w && bus.out_ready;

    // Words held plus the one in flight, minus the one leaving now; xfer implies occ >= 1, so no underflow.
    assign demand = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, xfer};
    assign rd_en  = !rst && !bus.fifo_empty && (demand < 3'd2);

    assign inflight_d = rd_en;

    always_ff @(posedge clk) begin
        if (rst) inflight_q <= 1'b0;
        else     inflight_q <= inflight_d;
    end

    argo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .pop_i   (xfer),
        .data_i  (bus.fifo_rd_data),
        .data_o  (head_data),
        .count_o (occ)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_valid  = out_valid_w;
    assign bus.out_data   = rst ? '0 : head_data;

`ifdef ARGO_CHAN_STATS_EN
    logic [CNT_WIDTH-1:0] pop_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] starve_cnt_q;
    logic                 stall_w;
    logic                 starve_w;

    assign stall_w  = out_valid_w && !bus.out_ready;
    assign starve_w = !rst && (occ == OCC_EMPTY) && bus.fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_cnt_q    <= '0;
            stall_cnt_q  <= '0;
            starve_cnt_q <= '0;
        end else begin
            if (rd_en) begin
                pop_cnt_q <= pop_cnt_q + 1'b1;
                if (pop_cnt_q == '1) $display("argo_chan_reader[%0d]: pop_count wrapped", CHAN_ID);
            end
            if (stall_w) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
                if (stall_cnt_q == '1) $display("argo_chan_reader[%0d]: stall_count wrapped", CHAN_ID);
            end
            if (starve_w) begin
                starve_cnt_q <= starve_cnt_q + 1'b1;
                if (starve_cnt_q == '1) $display("argo_chan_reader[%0d]: starve_count wrapped", CHAN_ID);
            end
        end
    end

    assign pop_count    = rst ? '0 : pop_cnt_q;
    assign stall_count  = rst ? '0 : stall_cnt_q;
    assign starve_count = rst ? '0 : starve_cnt_q;
`endif

endmodule

// File: tb/tb_argo_chan_reader.sv
// Bench for argo_chan_reader: behavioural argo_fifo, per-cycle vector table, scoreboard, stream and reset sequences.
module tb_argo_chan_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready_drv = 1'b0;
    logic [31:0] rd_data_q = '0;
    logic [31:0] fmem [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          xfer_cnt = 0;
    int          first_xfer = -1;
    int          last_xfer = -1;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    argo_chan_reader_if #(.DATA_WIDTH(32)) bus ();

    assign bus.fifo_empty   = (wr_ptr == rd_ptr);
    assign bus.fifo_rd_data = rd_data_q;
    assign bus.out_ready    = ready_drv;

`ifdef ARGO_CHAN_STATS_EN
    logic [31:0] pop_count;
    logic [31:0] stall_count;
    logic [31:0] starve_count;
`endif

    argo_chan_reader #(.DATA_WIDTH(32), .CHAN_ID(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ARGO_CHAN_STATS_EN
        ,
        .pop_count    (pop_count),
        .stall_count  (stall_count),
        .starve_count (starve_count)
`endif
    );

    // argo_fifo model: data one cycle after the pop, cleared by the shared reset
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) rd_ptr <= wr_ptr;
        else if (bus.fifo_rd_en) begin
            rd_data_q <= fmem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.fifo_rd_en) chk("pop_when_empty", 32'(bus.fifo_empty), 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_word", bus.out_data, 32'hFFFF_FFFF);
                else chk("word_order", bus.out_data, exp_q.pop_front());
                xfer_cnt++;
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer = cyc;
            end
        end
    end

    task automatic push_word(input logic [31:0] v);
        fmem[wr_ptr] = v;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ready_drv = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", bus.out_data, 32'd0);
`ifdef ARGO_CHAN_STATS_EN
        chk("rst_pop_count", pop_count, 32'd0);
`endif
        step();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cyc, input bit rand_ready);
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0) break;
            if (rand_ready) ready_drv = 1'($urandom_range(0, 1));
            step();
        end
        chk(name, exp_q.size(), 32'd0);
    endtask

    typedef struct {
        bit          do_rst;
        int          push_n;
        logic [31:0] push_v0;
        bit          ready;
        bit          exp_rd_en;
        bit          exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [$];

    initial begin
        int xfer_before;

        // basic flow: 1,2,3 with ready high; first word two cycles after the first pop
        vecs.push_back('{1, 3, 1, 1, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 1, 1, 1});
        vecs.push_back('{0, 0, 0, 1, 0, 1, 2});
        vecs.push_back('{0, 0, 0, 1, 0, 1, 3});
        vecs.push_back('{0, 0, 0, 1, 0, 0, 0});
        // backpressure: 5 queued, two pops then hold, release delivers 1..5
        vecs.push_back('{1, 5, 1, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 1, 1});
        vecs.push_back('{0, 0, 0, 0, 0, 1, 1});
        vecs.push_back('{0, 0, 0, 0, 0, 1, 1});
        vecs.push_back('{0, 0, 0, 1, 1, 1, 1});
        vecs.push_back('{0, 0, 0, 1, 1, 1, 2});
        vecs.push_back('{0, 0, 0, 1, 1, 1, 3});
        vecs.push_back('{0, 0, 0, 1, 0, 1, 4});
        vecs.push_back('{0, 0, 0, 1, 0, 1, 5});
        vecs.push_back('{0, 0, 0, 1, 0, 0, 0});
        // empty boundary: single word 7
        vecs.push_back('{1, 1, 7, 1, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 1, 7});
        vecs.push_back('{0, 0, 0, 1, 0, 0, 0});

        step();
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_rst) do_reset();
            for (int k = 0; k < vecs[i].push_n; k++) push_word(vecs[i].push_v0 + 32'(k));
            ready_drv = vecs[i].ready;
            #1;
            chk($sformatf("vec%0d_rd_en", i), 32'(bus.fifo_rd_en), 32'(vecs[i].exp_rd_en));
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) chk($sformatf("vec%0d_data", i), bus.out_data, vecs[i].exp_data);
            step();
        end
        chk("table_drained", exp_q.size(), 32'd0);

        // 100-word stream at full rate: transfers on 100 consecutive cycles
        do_reset();
        xfer_before = xfer_cnt;
        first_xfer = -1;
        for (int k = 0; k < 100; k++) push_word(32'd1000 + 32'(k));
        ready_drv = 1'b1;
        wait_drain("stream_drain", 300, 1'b0);
        chk("stream_count", 32'(xfer_cnt - xfer_before), 32'd100);
        chk("stream_span", 32'(last_xfer - first_xfer), 32'd99);

        // 100-word stream with random backpressure
        do_reset();
        xfer_before = xfer_cnt;
        for (int k = 0; k < 100; k++) push_word(32'd5000 + 32'(k));
        wait_drain("rand_drain", 2000, 1'b1);
        chk("rand_count", 32'(xfer_cnt - xfer_before), 32'd100);

        // reset with two words buffered, then word 42
        do_reset();
        for (int k = 0; k < 5; k++) push_word(32'd1 + 32'(k));
        step(); step(); step();
        chk("midrst_pre_valid", 32'(bus.out_valid), 32'd1);
        chk("midrst_pre_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        do_reset();
        #1;
        chk("midrst_post_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_post_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        xfer_before = xfer_cnt;
        push_word(32'd42);
        ready_drv = 1'b1;
        wait_drain("midrst_42", 20, 1'b0);
        chk("midrst_42_count", 32'(xfer_cnt - xfer_before), 32'd1);

`ifdef ARGO_CHAN_STATS_EN
        // stats: 10 words, ready low while four words wait
        do_reset();
        for (int k = 0; k < 10; k++) push_word(32'd200 + 32'(k));
        for (int c = 0; c < 6; c++) step();
        ready_drv = 1'b1;
        wait_drain("stats_drain", 50, 1'b0);
        step(); step();
        chk("pop_count", pop_count, 32'd10);
        chk("stall_count", stall_count, 32'd4);
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
